// File: rtl/sram_masked_if.sv
// Write/read port bundle for sram_masked. The master drives requests; the
// slave (the SRAM) returns read data, read-valid and ready.
interface sram_masked_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  wen;
  logic [ADDR_WIDTH-1:0] wadr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] radr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  ready;

  modport master (
    output wen, wadr, wdata, wstrb, ren, radr,
    input  rdata, rvalid, ready
  );

  modport slave (
    input  wen, wadr, wdata, wstrb, ren, radr,
    output rdata, rvalid, ready
  );
endinterface

// File: rtl/sram_masked.sv
// Byte-masked 1W1R SRAM with post-reset zero fill and same-address forwarding.
// Define SRAM_OUT_REG_EN to add a second output register stage (2-cycle read).
module sram_masked_lane (
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  input  logic       sel,
  output logic [7:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module sram_masked #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_masked_if.slave  bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
`ifdef SRAM_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  clr_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wadr_ok, radr_ok, wr_fire, rd_fire, fwd;
  logic [STRB_WIDTH-1:0][7:0] rd_raw, wdata_l, merged;
  logic [STRB_WIDTH-1:0] lane_sel;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [STAGES:1]                 vld_pipe;
  logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt == LAST) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // ---------------- array ----------------
  assign wadr_ok = {1'b0, bus.wadr} < DEPTH_W;
  assign radr_ok = {1'b0, bus.radr} < DEPTH_W;
  assign wr_fire = (state_q == READY) && bus.wen && wadr_ok;
  assign rd_fire = (state_q == READY) && bus.ren;
  assign fwd     = wr_fire && (bus.wadr == bus.radr);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < STRB_WIDTH; i++)
        if (bus.wstrb[i]) mem[bus.wadr][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
  end

  // Read word is the post-write value when the write hits the read address.
  assign rd_raw   = mem[bus.radr];
  assign wdata_l  = bus.wdata;
  assign lane_sel = {STRB_WIDTH{fwd}} & bus.wstrb;

  for (genvar g = 0; g < STRB_WIDTH; g++) begin : g_lane
    sram_masked_lane u_lane (
      .old_b (rd_raw[g]),
      .new_b (wdata_l[g]),
      .sel   (lane_sel[g]),
      .out_b (merged[g])
    );
  end

  assign rd_word = radr_ok ? merged : '0;

  // ---------------- output pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_fire;
      if (rd_fire) dat_pipe[1] <= rd_word;
`ifdef SRAM_OUT_REG_EN
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) dat_pipe[2] <= dat_pipe[1];
`endif
    end
  end

  assign bus.rdata  = dat_pipe[STAGES];
  assign bus.rvalid = vld_pipe[STAGES];
  assign bus.ready  = (state_q == READY);
endmodule

// File: tb/tb_sram_masked.sv
// Directed bench for sram_masked: a per-cycle reference model plus
// hand-computed literal reads.
module tb_sram_masked;
  localparam int DW    = 128;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;
  localparam int SW    = DW / 8;
`ifdef SRAM_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_masked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_masked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: array semantics, write applied before the read so a
  // same-address read observes the post-write word.
  logic [DW-1:0] m [DEPTH];
  int            m_cnt;
  logic          m_rdy;
  logic [DW-1:0] d1, d2, ed;
  logic          v1, v2, ev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_rdy = 1'b0;
      d1 = '0; v1 = 1'b0; d2 = '0; v2 = 1'b0;
    end else begin
      v2 = v1;
      if (v1) d2 = d1;
      if (!m_rdy) begin
        m[m_cnt] = '0;
        m_cnt++;
        m_rdy = (m_cnt == DEPTH);
        v1 = 1'b0;
      end else begin
        if (bus.wen && bus.wadr < DEPTH)
          for (int i = 0; i < SW; i++)
            if (bus.wstrb[i]) m[bus.wadr][8*i +: 8] = bus.wdata[8*i +: 8];
        v1 = bus.ren;
        if (bus.ren) d1 = (bus.radr < DEPTH) ? m[bus.radr] : '0;
      end
    end
  end

  assign ev = (STAGES == 2) ? v2 : v1;
  assign ed = (STAGES == 2) ? d2 : d1;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("model_ready",  DW'(bus.ready),  DW'(m_rdy));
      chk("model_rvalid", DW'(bus.rvalid), DW'(ev));
      chk("model_rdata",  bus.rdata, ed);
    end
  end

  // Inputs change at negedge; one posedge falls inside each step.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [SW-1:0] ws, input logic r, input logic [AW-1:0] ra);
    bus.wen = w; bus.wadr = wa; bus.wdata = wd; bus.wstrb = ws;
    bus.ren = r; bus.radr = ra;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    step(1'b1, a, d, s, 1'b0, '0);
  endtask

  task automatic rd(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    step(1'b0, '0, '0, '0, 1'b1, a);
    repeat (STAGES - 1) idle();
    chk(nm, bus.rdata, exp);
    chk({nm, "_rvalid"}, DW'(bus.rvalid), DW'(1));
  endtask

  // Drives a write+read at 3 (must be ignored) until ready; edge count must equal DEPTH.
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.ready && n < DEPTH + 20) begin
      step(1'b1, 10'd3, DW'(7), '1, 1'b1, 10'd3);
      n++;
    end
    chk(nm, DW'(n), DW'(DEPTH));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.wen = 0; bus.wadr = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.ren = 0; bus.radr = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_rdata",  bus.rdata, '0);
    chk("rst_rvalid", DW'(bus.rvalid), '0);
    chk("rst_ready",  DW'(bus.ready), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wait_ready("clear_edges");
    rd("clear_r5", 10'd5, '0);
    rd("clear_r3", 10'd3, '0);

    wr(10'd97, DW'(137), '1);
    rd("basic_r97", 10'd97, DW'(137));
    idle();
    chk("basic_rvalid_drop", DW'(bus.rvalid), '0);
    chk("basic_rdata_hold",  bus.rdata, DW'(137));

    wr(10'd10, DW'(32'hAABBCCDD), '1);
    wr(10'd10, DW'(8'h11), SW'(1));
    rd("partial_r10", 10'd10, DW'(32'hAABBCC11));

    wr(10'd97, DW'(5), '0);
    rd("nostrb_r97", 10'd97, DW'(137));

    wr(10'd83, {DW{1'b1}}, '1);
    step(1'b1, 10'd83, DW'(84), '1, 1'b1, 10'd83);
    repeat (STAGES - 1) idle();
    chk("fwd_full", bus.rdata, DW'(84));
    rd("fwd_later", 10'd83, DW'(84));

    step(1'b1, 10'd83, DW'(16'h1200), SW'(2), 1'b1, 10'd83);
    repeat (STAGES - 1) idle();
    chk("fwd_partial", bus.rdata, DW'(16'h1254));

    step(1'b1, 10'd30, DW'(8'h33), '1, 1'b1, 10'd97);
    repeat (STAGES - 1) idle();
    chk("diff_addr_r97", bus.rdata, DW'(137));
    rd("diff_addr_r30", 10'd30, DW'(8'h33));

    wr(10'd1010, DW'(9), '1);
    rd("oor_r1010", 10'd1010, '0);
    rd("oor_r10",   10'd10, DW'(32'hAABBCC11));

    // Back-to-back reads
    step(1'b0, '0, '0, '0, 1'b1, 10'd10);
    step(1'b0, '0, '0, '0, 1'b1, 10'd30);
    idle();
    idle();

    wr(10'd20, DW'(55), '1);
    step(1'b0, '0, '0, '0, 1'b1, 10'd97);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdata",  bus.rdata, '0);
    chk("midrst_rvalid", DW'(bus.rvalid), '0);
    chk("midrst_ready",  DW'(bus.ready), '0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reclear_edges");
    rd("reclear_r20", 10'd20, '0);
    rd("reclear_r97", 10'd97, '0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_masked.md
Name: sram_masked

Overview:
Parametrised successor to the simple dual-port SRAM: one write port and one read port on a single clock. Adds per-byte write strobes, a read-valid flag and same-address read-during-write forwarding. A hardware clear sequencer zeroes every entry after reset before the array accepts traffic. Used as the generic on-chip buffer for enclave datapaths that need partial-word updates and deterministic initial contents.

Parameters:
DATA_WIDTH, 128, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, address width in bits.
DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
Derived localparam STRB_WIDTH = DATA_WIDTH/8; not overridable.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
wen  input  1  write enable.
wadr  input  ADDR_WIDTH  write address.
wdata  input  DATA_WIDTH  write data.
wstrb  input  STRB_WIDTH  byte-lane write mask; bit i covers wdata[8i+7:8i].
ren  input  1  read enable.
radr  input  ADDR_WIDTH  read address.
rdata  output  DATA_WIDTH  registered read data.
rvalid  output  1  rdata holds the result of a read issued one cycle earlier.
ready  output  1  clear sequence finished; accesses are honoured.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset asserted: rdata=0, rvalid=0, ready=0, clear counter=0, FSM=CLEAR. Memory contents are not reset directly.
- FSM CLEAR: each cycle writes all-zero to mem[cnt] and increments cnt. After cnt=DEPTH-1 is written, the next state is READY and ready=1.
- ready rises on the DEPTH-th rising edge after rst_n deasserts (edge 1 clears entry 0).
- In CLEAR, wen and ren are ignored: no array write from the ports, rvalid stays 0, rdata stays 0.
- FSM READY is terminal until the next reset.
- Write (READY): when wen=1 and wadr<DEPTH, each lane with wstrb[i]=1 takes wdata lane i. Lanes with wstrb[i]=0 keep their old value. wstrb=0 performs no change.
- Read (READY): when ren=1, at the edge rdata <= mem[radr] and rvalid <= 1. Latency is 1 cycle.
- When ren=0: rvalid <= 0 and rdata holds its previous value.
- Read-during-write at the same address (wen=ren=1, wadr==radr): rdata returns the post-write word. Strobed lanes come from wdata; unstrobed lanes come from the old contents. The write also lands in the array.
- Different addresses on the same cycle: independent; no stall.
- Out of range (address >= DEPTH, only when DEPTH < 2**ADDR_WIDTH): the write is dropped; a read returns 0 with rvalid=1.
- Reset mid-operation: outputs clear immediately. Any in-flight read is lost. FSM returns to CLEAR and the full array is re-zeroed.

Optional Feature:
SRAM_OUT_REG_EN:
- Defined: adds a second output register stage. Read latency becomes 2 cycles; rvalid is pipelined alongside the data.
- Stage 2 holds its value when its valid bit is 0. Forwarding is applied at stage 1, so results stay post-write.
- Reset clears both stages.
- Undefined: 1-cycle latency exactly as specified above.

Test Plan:
- Clear sequence: release rst_n, DEPTH=1024 -> ready=0 for edges 1-1023 and 1 after edge 1024. Then ren, radr=5 -> rdata=0, rvalid=1 next cycle.
- Basic write/read: write wdata=137 to wadr=97 with wstrb all-ones. Next cycle ren, radr=97 -> rdata=137 one cycle later, rvalid high for exactly that cycle.
- Partial strobe: write 0xAABBCCDD at 10 with full strobe. Then write wdata=0x11, wstrb=0x0001 at 10. Read 10 -> low 32 bits 0xAABBCC11.
- Forwarding: with 83 holding 0xFF..FF, same cycle wen=1, wadr=83, wdata=84, wstrb all-ones and ren=1, radr=83 -> rdata=84. A later read of 83 -> 84.
- Ignored during clear: wen=1, wadr=3, wdata=7 and ren=1 while ready=0 -> rvalid stays 0. After ready, reading 3 -> 0.
- Reset mid-operation: write 55 to 20, assert rst_n low mid-cycle -> rdata=0, rvalid=0, ready=0 immediately. After re-clear, reading 20 -> 0.
- With SRAM_OUT_REG_EN: repeat the basic write/read -> rdata=137 and rvalid=1 two cycles after ren.
